regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWrite/wa/wd) between NREQ
//   writeback requesters using round-robin arbitration and valid/ready handshakes.
//   Keeps a 32-entry busy scoreboard (set on reserve, cleared on commit) so the
//   decode stage can detect RAW hazards on the two read addresses ra1/ra2.
//   Sits between the execute/memory writeback sources and the register file.
// PARAMETERS
//   NREQ        2   number of writeback requesters (2..8)
//   DISCARD_R0  1   1: writes to register 0 are accepted but never driven to RegWrite
// PORTS
//   clk            in   1         rising-edge clock
//   rst_n          in   1         synchronous reset, active low
//   stall          in   1         freeze arbitration (no grants while high)
//   req_valid      in   NREQ      requester i has a write pending
//   req_ready      out  NREQ      one-hot grant; transfer when valid&ready
//   req_wa         in   NREQ*5    dest reg per requester, slice [5i+4:5i]
//   req_wd         in   NREQ*32   data per requester, slice [32i+31:32i]
//   RegWrite       out  1         to register file write enable (registered)
//   wa             out  5         to register file write address (registered)
//   wd             out  32        to register file write data (registered)
//   reserve_valid  in   1         decode issued an instr that will write reserve_wa
//   reserve_wa     in   5         dest reg being reserved
//   ra1, ra2       in   5         decode read addresses
//   hazard1        out  1         busy[ra1] (combinational)
//   hazard2        out  1         busy[ra2] (combinational)
//   busy           out  32        scoreboard vector
//   commit_cnt     out  16        count of RegWrite pulses, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): RegWrite=0, wa=0, wd=0, busy=0, commit_cnt=0,
//     rr_ptr=NREQ-1 (so requester 0 has first priority). Reset mid-transfer
//     discards the in-flight write; no RegWrite pulse follows reset.
//   Arbitration (combinational): if stall=1 or no valid, req_ready=0. Else grant g =
//     first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
//     req_ready is one-hot; it may depend on req_valid. Requesters hold valid/wa/wd
//     stable until ready.
//   On transfer (posedge): rr_ptr<=g; wa<=req_wa[g]; wd<=req_wd[g];
//     RegWrite<=1, unless DISCARD_R0=1 and req_wa[g]=0 (then RegWrite<=0 but the
//     grant still consumes the turn). No transfer: RegWrite<=0; wa/wd hold.
//   Latency: grant at edge N -> RegWrite high during cycle N+1; the regfile writes
//     at edge N+2. Throughput is one write/cycle; no back-pressure from the regfile.
//   Scoreboard, at each posedge:
//     clear busy[wa] if RegWrite=1 (same edge the regfile captures wd);
//     then set busy[reserve_wa] if reserve_valid=1. Set wins on same address.
//     With DISCARD_R0=1, busy[0] is forced 0 and a reserve of r0 is ignored.
//     Reserving an already-busy reg leaves it busy (no count; one writer/reg).
//   commit_cnt increments on each edge where RegWrite=1.
//   stall asserted mid-stream: takes effect the same cycle (ready drops);
//     a RegWrite already registered still completes.
// TESTING
//   1) Reset 2 cycles -> RegWrite=0, wa=0, wd=0, busy=0, req_ready=0, commit_cnt=0.
//   2) NREQ=2, both valid continuously (r0:wa=5/wd=0xA, r1:wa=6/wd=0xB) -> grants
//      alternate 0,1,0,1; RegWrite high every cycle; wa 5,6,5,6 one cycle after grant.
//   3) Single requester wa=0, wd=0xFFFF_FFFF, DISCARD_R0=1 -> ready=1 one cycle,
//      RegWrite stays 0, commit_cnt unchanged, busy[0]=0.
//   4) reserve r7, ra1=7 -> hazard1=1 next cycle; write wa=7 granted -> busy[7]
//      clears at edge after RegWrite pulse; same edge reserve r7 again -> stays 1.
//   5) stall=1 with both valid for 3 cycles -> req_ready=0, RegWrite=0 after the
//      in-flight one; stall=0 -> round-robin resumes from the saved rr_ptr.
//   6) rst_n low for one edge during continuous grants -> next cycle RegWrite=0,
//      busy=0; requester 0 granted first after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port plus a busy scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int DISCARD_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*5-1:0] req_wa,
  input  logic [NREQ*32-1:0] req_wd,
  output logic              RegWrite,
  output logic [4:0]        wa,
  output logic [31:0]       wd,
  input  logic              reserve_valid,
  input  logic [4:0]        reserve_wa,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [31:0]       busy,
  output logic [15:0]       commit_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] rr_ptr, g;
  logic          any, go;
  logic [4:0]    sel_wa;
  logic [31:0]   sel_wd, busy_nxt;
  // Walk from farthest to nearest so the requester closest after rr_ptr wins.
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        g = PW'((int'(rr_ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
  assign go        = any && !stall;
  assign req_ready = go ? (NREQ'(1) << g) : '0;
  assign sel_wa    = req_wa[5*g +: 5];
  assign sel_wd    = req_wd[32*g +: 32];
  assign hazard1   = busy[ra1];
  assign hazard2   = busy[ra2];
  // Commit clears first so a same-edge reserve of the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (RegWrite) busy_nxt[wa] = 1'b0;
    if (reserve_valid) busy_nxt[reserve_wa] = 1'b1;
    if (DISCARD_R0 != 0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      busy       <= '0;
      commit_cnt <= '0;
      rr_ptr     <= PW'(NREQ - 1);
    end else begin
      RegWrite   <= go && !(DISCARD_R0 != 0 && sel_wa == 5'd0);
      busy       <= busy_nxt;
      commit_cnt <= commit_cnt + 16'(RegWrite);
      if (go) begin
        rr_ptr <= g;
        wa     <= sel_wa;
        wd     <= sel_wd;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with hand-computed expectations for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, stall, reserve_valid, RegWrite, hazard1, hazard2;
  logic [1:0]  req_valid, req_ready;
  logic [9:0]  req_wa;
  logic [63:0] req_wd;
  logic [4:0]  wa, reserve_wa, ra1, ra2;
  logic [31:0] wd, busy;
  logic [15:0] commit_cnt;
  int vec = 0, err = 0;

  regfile_wb_arbiter #(.NREQ(2), .DISCARD_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_wa(req_wa), .req_wd(req_wd), .RegWrite(RegWrite), .wa(wa), .wd(wd),
    .reserve_valid(reserve_valid), .reserve_wa(reserve_wa), .ra1(ra1), .ra2(ra2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; reserve_valid = 1'b0; reserve_wa = '0;
    req_valid = '0; req_wa = '0; req_wd = '0; ra1 = '0; ra2 = '0;
    step(); step();
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_wd", wd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_cnt", 32'(commit_cnt), 0);
    rst_n = 1'b1;

    req_wa = {5'd6, 5'd5};
    req_wd = {32'hB, 32'hA};
    req_valid = 2'b11;
    #1 chk("rr_first_ready", 32'(req_ready), 32'b01);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_ready", 32'(req_ready), (i % 2) ? 32'b01 : 32'b10);
      chk("rr_regwrite", 32'(RegWrite), 1);
      chk("rr_wa", 32'(wa), (i % 2) ? 32'd6 : 32'd5);
      chk("rr_wd", wd, (i % 2) ? 32'hB : 32'hA);
      chk("rr_cnt", 32'(commit_cnt), 32'(i));
    end
    req_valid = 2'b00;
    step();
    chk("idle_regwrite", 32'(RegWrite), 0);
    chk("idle_wa_hold", 32'(wa), 6);
    chk("idle_cnt", 32'(commit_cnt), 4);

    req_wa = {5'd6, 5'd0};
    req_wd = {32'hB, 32'hFFFF_FFFF};
    req_valid = 2'b01;
    reserve_valid = 1'b1; reserve_wa = 5'd0;
    #1 chk("r0_ready", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00; reserve_valid = 1'b0;
    #1 chk("r0_ready_drop", 32'(req_ready), 0);
    chk("r0_regwrite", 32'(RegWrite), 0);
    chk("r0_busy", busy, 0);
    step();
    chk("r0_cnt", 32'(commit_cnt), 4);

    ra1 = 5'd7; ra2 = 5'd3;
    reserve_valid = 1'b1; reserve_wa = 5'd7;
    #1 chk("haz_before", 32'(hazard1), 0);
    step();
    reserve_valid = 1'b0;
    chk("haz1_set", 32'(hazard1), 1);
    chk("haz2_clear", 32'(hazard2), 0);
    chk("busy7_set", busy, 32'h80);
    req_wa = {5'd7, 5'd5};
    req_wd = {32'h77, 32'hA};
    req_valid = 2'b10;
    #1 chk("w7_ready", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b00;
    chk("w7_regwrite", 32'(RegWrite), 1);
    chk("w7_wa", 32'(wa), 7);
    chk("w7_wd", wd, 32'h77);
    chk("w7_busy_held", busy, 32'h80);
    step();
    chk("w7_busy_clear", busy, 0);
    chk("w7_haz_clear", 32'(hazard1), 0);
    chk("w7_cnt", 32'(commit_cnt), 5);
    reserve_valid = 1'b1; reserve_wa = 5'd7;
    step();
    reserve_valid = 1'b0;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    chk("w7b_regwrite", 32'(RegWrite), 1);
    reserve_valid = 1'b1; reserve_wa = 5'd7;
    step();
    reserve_valid = 1'b0;
    chk("w7b_set_wins", busy, 32'h80);
    chk("w7b_cnt", 32'(commit_cnt), 6);

    req_wa = {5'd6, 5'd5};
    req_wd = {32'hB, 32'hA};
    req_valid = 2'b11;
    step();
    chk("st_pre_wa", 32'(wa), 5);
    stall = 1'b1;
    #1 chk("st_ready_now", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_ready", 32'(req_ready), 0);
      chk("st_regwrite", 32'(RegWrite), 0);
    end
    chk("st_cnt", 32'(commit_cnt), 7);
    stall = 1'b0;
    #1 chk("st_resume_ready", 32'(req_ready), 32'b10);
    step();
    chk("st_resume_wa", 32'(wa), 6);
    chk("st_resume_regwrite", 32'(RegWrite), 1);

    rst_n = 1'b0;
    step();
    chk("mrst_regwrite", 32'(RegWrite), 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", 32'(commit_cnt), 0);
    rst_n = 1'b1;
    #1 chk("mrst_ready", 32'(req_ready), 32'b01);
    step();
    chk("mrst_first_wa", 32'(wa), 5);
    chk("mrst_first_regwrite", 32'(RegWrite), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
